// File: rtl/io_request_arbiter.sv
// Round-robin share of the IO request port between master A and B; reads return in order via a tag FIFO.
// Accept->oIO_* in 1 cycle, 1/cycle; busy on IO stall or tag FIFO full (reads); returns stall on head-master busy.
module io_request_arbiter #(
    parameter int TAG_DEPTH   = 4,
    parameter int TAG_DEPTH_N = 2
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    // master A
    input  logic        iA_REQ,
    output logic        oA_BUSY,
    input  logic [1:0]  iA_ORDER,
    input  logic        iA_RW,
    input  logic [31:0] iA_ADDR,
    input  logic [31:0] iA_DATA,
    output logic        oA_VALID,
    input  logic        iA_BUSY,
    output logic [31:0] oA_DATA,
    // master B
    input  logic        iB_REQ,
    output logic        oB_BUSY,
    input  logic [1:0]  iB_ORDER,
    input  logic        iB_RW,
    input  logic [31:0] iB_ADDR,
    input  logic [31:0] iB_DATA,
    output logic        oB_VALID,
    input  logic        iB_BUSY,
    output logic [31:0] oB_DATA,
    // IO controller
    output logic        oIO_REQ,
    input  logic        iIO_BUSY,
    output logic [1:0]  oIO_ORDER,
    output logic        oIO_RW,
    output logic [31:0] oIO_ADDR,
    output logic [31:0] oIO_DATA,
    input  logic        iIO_VALID,
    output logic        oIO_BUSY,
    input  logic [31:0] iIO_DATA,
    output logic        oERROR
);

    localparam logic [TAG_DEPTH_N+1:0] LP_DEPTH = (TAG_DEPTH_N+2)'(TAG_DEPTH);

    logic                   r_slot_vld;
    logic                   r_slot_id;
    logic [1:0]             r_slot_order;
    logic                   r_slot_rw;
    logic [31:0]            r_slot_addr;
    logic [31:0]            r_slot_data;
    logic                   r_rr_b;
    logic [TAG_DEPTH-1:0]   r_id_mem;
    logic [TAG_DEPTH_N-1:0] r_wr_ptr;
    logic [TAG_DEPTH_N-1:0] r_rd_ptr;
    logic [TAG_DEPTH_N:0]   r_count;
    logic                   r_error;

    logic                   w_slot_free;
    logic                   w_pending;
    logic [TAG_DEPTH_N+1:0] w_inflight;
    logic                   w_full;
    logic                   w_elig_a;
    logic                   w_elig_b;
    logic                   w_grant_a;
    logic                   w_grant_b;
    logic                   w_slave_xfer;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_cnt_nz;
    logic                   w_head;
    logic                   w_head_busy;

    // A read sitting in the slot will push on transfer, so it counts against capacity now
    assign w_slot_free  = !r_slot_vld || !iIO_BUSY;
    assign w_pending    = r_slot_vld && r_slot_rw;
    assign w_inflight   = {1'b0, r_count} + {{(TAG_DEPTH_N+1){1'b0}}, w_pending};
    assign w_full       = (w_inflight >= LP_DEPTH);

    assign w_elig_a     = iA_REQ && w_slot_free && (!iA_RW || !w_full);
    assign w_elig_b     = iB_REQ && w_slot_free && (!iB_RW || !w_full);
    assign w_grant_a    = w_elig_a && (!w_elig_b || !r_rr_b);
    assign w_grant_b    = w_elig_b && (!w_elig_a ||  r_rr_b);

    assign oA_BUSY      = !w_grant_a;
    assign oB_BUSY      = !w_grant_b;

    assign w_slave_xfer = r_slot_vld && !iIO_BUSY;
    assign w_push       = w_slave_xfer && r_slot_rw;

    assign w_cnt_nz     = (r_count != '0);
    assign w_head       = r_id_mem[r_rd_ptr];
    assign w_head_busy  = w_head ? iB_BUSY : iA_BUSY;
    assign w_pop        = iIO_VALID && w_cnt_nz && !w_head_busy;

    assign oIO_REQ      = r_slot_vld;
    assign oIO_ORDER    = r_slot_order;
    assign oIO_RW       = r_slot_rw;
    assign oIO_ADDR     = r_slot_addr;
    assign oIO_DATA     = r_slot_data;
    assign oIO_BUSY     = w_cnt_nz && w_head_busy;

    assign oA_VALID     = iIO_VALID && w_cnt_nz && !w_head;
    assign oB_VALID     = iIO_VALID && w_cnt_nz &&  w_head;
    assign oA_DATA      = oA_VALID ? iIO_DATA : 32'h0;
    assign oB_DATA      = oB_VALID ? iIO_DATA : 32'h0;
    assign oERROR       = r_error;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_slot_vld   <= 1'b0;
            r_slot_id    <= 1'b0;
            r_slot_order <= 2'b00;
            r_slot_rw    <= 1'b0;
            r_slot_addr  <= 32'h0;
            r_slot_data  <= 32'h0;
        end else if (w_grant_a || w_grant_b) begin
            r_slot_vld   <= 1'b1;
            r_slot_id    <= w_grant_b;
            r_slot_order <= w_grant_b ? iB_ORDER : iA_ORDER;
            r_slot_rw    <= w_grant_b ? iB_RW    : iA_RW;
            r_slot_addr  <= w_grant_b ? iB_ADDR  : iA_ADDR;
            r_slot_data  <= w_grant_b ? iB_DATA  : iA_DATA;
        end else if (w_slave_xfer) begin
            r_slot_vld   <= 1'b0;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_rr_b <= 1'b0;
        end else if (w_grant_a) begin
            r_rr_b <= 1'b1;
        end else if (w_grant_b) begin
            r_rr_b <= 1'b0;
        end
    end

    // Tag FIFO: one master id per outstanding read, popped as returns are accepted
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_id_mem <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_id_mem[r_wr_ptr] <= r_slot_id;
                r_wr_ptr           <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_error <= 1'b0;
        end else begin
            r_error <= iIO_VALID && !w_cnt_nz;
        end
    end

endmodule

// File: tb/tb_io_request_arbiter.sv
// Directed vector table plus hand sequences for full-FIFO, IO stall and async reset.
module tb_io_request_arbiter;

    logic        iCLOCK;
    logic        inRESET;
    logic        iA_REQ, iA_RW, iA_BUSY, oA_BUSY, oA_VALID;
    logic [1:0]  iA_ORDER;
    logic [31:0] iA_ADDR, iA_DATA, oA_DATA;
    logic        iB_REQ, iB_RW, iB_BUSY, oB_BUSY, oB_VALID;
    logic [1:0]  iB_ORDER;
    logic [31:0] iB_ADDR, iB_DATA, oB_DATA;
    logic        oIO_REQ, iIO_BUSY, oIO_RW, iIO_VALID, oIO_BUSY, oERROR;
    logic [1:0]  oIO_ORDER;
    logic [31:0] oIO_ADDR, oIO_DATA, iIO_DATA;

    int n_cmp = 0;
    int n_bad = 0;

    io_request_arbiter #(.TAG_DEPTH(4), .TAG_DEPTH_N(2)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET),
        .iA_REQ(iA_REQ), .oA_BUSY(oA_BUSY), .iA_ORDER(iA_ORDER), .iA_RW(iA_RW),
        .iA_ADDR(iA_ADDR), .iA_DATA(iA_DATA), .oA_VALID(oA_VALID), .iA_BUSY(iA_BUSY),
        .oA_DATA(oA_DATA),
        .iB_REQ(iB_REQ), .oB_BUSY(oB_BUSY), .iB_ORDER(iB_ORDER), .iB_RW(iB_RW),
        .iB_ADDR(iB_ADDR), .iB_DATA(iB_DATA), .oB_VALID(oB_VALID), .iB_BUSY(iB_BUSY),
        .oB_DATA(oB_DATA),
        .oIO_REQ(oIO_REQ), .iIO_BUSY(iIO_BUSY), .oIO_ORDER(oIO_ORDER), .oIO_RW(oIO_RW),
        .oIO_ADDR(oIO_ADDR), .oIO_DATA(oIO_DATA), .iIO_VALID(iIO_VALID),
        .oIO_BUSY(oIO_BUSY), .iIO_DATA(iIO_DATA), .oERROR(oERROR)
    );

    initial begin
        iCLOCK = 1'b0;
        forever #5 iCLOCK = ~iCLOCK;
    end

    typedef struct {
        logic        a_req, a_rw;
        logic [31:0] a_addr;
        logic        b_req, b_rw;
        logic [31:0] b_addr;
        logic        io_busy, io_vld;
        logic [31:0] io_dat;
        logic        a_bsy, b_bsy;
        logic        e_abusy, e_bbusy, e_ioreq;
        logic [31:0] e_ioaddr;
        logic        e_iorw, e_avld, e_bvld, e_iobusy, e_err;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(
        input logic a_req, input logic a_rw, input logic [31:0] a_addr,
        input logic b_req, input logic b_rw, input logic [31:0] b_addr,
        input logic io_busy, input logic io_vld, input logic [31:0] io_dat,
        input logic a_bsy, input logic b_bsy,
        input logic e_abusy, input logic e_bbusy, input logic e_ioreq,
        input logic [31:0] e_ioaddr, input logic e_iorw,
        input logic e_avld, input logic e_bvld, input logic e_iobusy, input logic e_err);
        vec_t v;
        v.a_req = a_req;     v.a_rw = a_rw;       v.a_addr = a_addr;
        v.b_req = b_req;     v.b_rw = b_rw;       v.b_addr = b_addr;
        v.io_busy = io_busy; v.io_vld = io_vld;   v.io_dat = io_dat;
        v.a_bsy = a_bsy;     v.b_bsy = b_bsy;
        v.e_abusy = e_abusy; v.e_bbusy = e_bbusy; v.e_ioreq = e_ioreq;
        v.e_ioaddr = e_ioaddr; v.e_iorw = e_iorw;
        v.e_avld = e_avld;   v.e_bvld = e_bvld;   v.e_iobusy = e_iobusy; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        iA_REQ = 0; iA_RW = 0; iA_ADDR = 0; iA_DATA = 32'hA5A5_0000; iA_ORDER = 2'd0; iA_BUSY = 0;
        iB_REQ = 0; iB_RW = 0; iB_ADDR = 0; iB_DATA = 32'hB5B5_0000; iB_ORDER = 2'd0; iB_BUSY = 0;
        iIO_BUSY = 0; iIO_VALID = 0; iIO_DATA = 0;
    endtask

    task automatic apply(input vec_t v);
        drive_idle();
        iA_REQ = v.a_req; iA_RW = v.a_rw; iA_ADDR = v.a_addr; iA_BUSY = v.a_bsy;
        iB_REQ = v.b_req; iB_RW = v.b_rw; iB_ADDR = v.b_addr; iB_BUSY = v.b_bsy;
        iIO_BUSY = v.io_busy; iIO_VALID = v.io_vld; iIO_DATA = v.io_dat;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        check($sformatf("v%0d a_busy", i), {63'd0, oA_BUSY}, {63'd0, v.e_abusy});
        check($sformatf("v%0d b_busy", i), {63'd0, oB_BUSY}, {63'd0, v.e_bbusy});
        check($sformatf("v%0d io_req", i), {63'd0, oIO_REQ}, {63'd0, v.e_ioreq});
        if (v.e_ioreq) begin
            check($sformatf("v%0d io_addr", i), {32'd0, oIO_ADDR}, {32'd0, v.e_ioaddr});
            check($sformatf("v%0d io_rw", i), {63'd0, oIO_RW}, {63'd0, v.e_iorw});
        end
        check($sformatf("v%0d a_valid", i), {63'd0, oA_VALID}, {63'd0, v.e_avld});
        check($sformatf("v%0d b_valid", i), {63'd0, oB_VALID}, {63'd0, v.e_bvld});
        check($sformatf("v%0d a_data", i), {32'd0, oA_DATA}, {32'd0, (v.e_avld ? v.io_dat : 32'h0)});
        check($sformatf("v%0d b_data", i), {32'd0, oB_DATA}, {32'd0, (v.e_bvld ? v.io_dat : 32'h0)});
        check($sformatf("v%0d io_busy", i), {63'd0, oIO_BUSY}, {63'd0, v.e_iobusy});
        check($sformatf("v%0d error", i), {63'd0, oERROR}, {63'd0, v.e_err});
    endtask

    initial begin
        // Read storm A,B,A,B then in-order returns, head-busy stall and empty-return error
        //             a_req rw addr     b_req rw addr     iob vld dat     ab bb | eab ebb ereq eaddr    erw eav ebv eiob err
        tbl[0]  = mk(1, 1, 32'h100, 1, 1, 32'h200, 0, 0, 32'h00, 0, 0,   0, 1, 0, 32'h000, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 32'h104, 1, 1, 32'h200, 0, 0, 32'h00, 0, 0,   1, 0, 1, 32'h100, 1, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 32'h104, 1, 1, 32'h204, 0, 0, 32'h00, 0, 0,   0, 1, 1, 32'h200, 1, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 32'h108, 1, 1, 32'h204, 0, 0, 32'h00, 0, 0,   1, 0, 1, 32'h104, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h00, 0, 0,   1, 1, 1, 32'h204, 1, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 32'h000, 0, 0, 32'h000, 0, 1, 32'h11, 0, 0,   1, 1, 0, 32'h000, 0, 1, 0, 0, 0);
        tbl[6]  = mk(0, 0, 32'h000, 0, 0, 32'h000, 0, 1, 32'h22, 0, 0,   1, 1, 0, 32'h000, 0, 0, 1, 0, 0);
        tbl[7]  = mk(0, 0, 32'h000, 0, 0, 32'h000, 0, 1, 32'h33, 1, 0,   1, 1, 0, 32'h000, 0, 1, 0, 1, 0);
        tbl[8]  = mk(0, 0, 32'h000, 0, 0, 32'h000, 0, 1, 32'h33, 0, 0,   1, 1, 0, 32'h000, 0, 1, 0, 0, 0);
        tbl[9]  = mk(0, 0, 32'h000, 0, 0, 32'h000, 0, 1, 32'h44, 0, 0,   1, 1, 0, 32'h000, 0, 0, 1, 0, 0);
        tbl[10] = mk(0, 0, 32'h000, 0, 0, 32'h000, 0, 1, 32'h55, 0, 0,   1, 1, 0, 32'h000, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h00, 0, 0,   1, 1, 0, 32'h000, 0, 0, 0, 0, 1);
        tbl[12] = mk(0, 0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h00, 0, 0,   1, 1, 0, 32'h000, 0, 0, 0, 0, 0);

        drive_idle();
        inRESET = 1'b0;
        repeat (3) @(negedge iCLOCK);
        check("reset io_req", {63'd0, oIO_REQ}, 64'd0);
        check("reset error", {63'd0, oERROR}, 64'd0);
        check("reset io_busy", {63'd0, oIO_BUSY}, 64'd0);
        inRESET = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge iCLOCK);
            apply(tbl[i]);
            #2;
            check_vec(i, tbl[i]);
        end

        // Single A write: one-cycle latency, no tag pushed
        @(negedge iCLOCK);
        drive_idle();
        iA_REQ = 1; iA_RW = 0; iA_ADDR = 32'h204; iA_DATA = 32'hDEADBEEF; iA_ORDER = 2'd1;
        #2 check("wr a_busy", {63'd0, oA_BUSY}, 64'd0);
        @(negedge iCLOCK);
        drive_idle();
        iA_BUSY = 1; iB_BUSY = 1;
        #2;
        check("wr io_req", {63'd0, oIO_REQ}, 64'd1);
        check("wr io_addr", {32'd0, oIO_ADDR}, 64'h204);
        check("wr io_rw", {63'd0, oIO_RW}, 64'd0);
        check("wr io_data", {32'd0, oIO_DATA}, 64'hDEADBEEF);
        check("wr io_order", {62'd0, oIO_ORDER}, 64'd1);
        @(negedge iCLOCK);
        #2;
        check("wr slot cleared", {63'd0, oIO_REQ}, 64'd0);
        check("wr no tag", {63'd0, oIO_BUSY}, 64'd0);

        // B fills the tag FIFO; fifth read blocked while an A write still goes through
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLOCK);
            drive_idle();
            iB_REQ = 1; iB_RW = 1; iB_ADDR = 32'h300 + 32'(4 * i);
            #2 check($sformatf("fill b_busy %0d", i), {63'd0, oB_BUSY}, 64'd0);
        end
        @(negedge iCLOCK);
        drive_idle();
        iB_REQ = 1; iB_RW = 1; iB_ADDR = 32'h310;
        iA_REQ = 1; iA_RW = 0; iA_ADDR = 32'h400;
        #2;
        check("full b_busy", {63'd0, oB_BUSY}, 64'd1);
        check("full a_write", {63'd0, oA_BUSY}, 64'd0);
        @(negedge iCLOCK);
        iA_REQ = 0;
        #2;
        check("full b_busy2", {63'd0, oB_BUSY}, 64'd1);
        check("full io_addr", {32'd0, oIO_ADDR}, 64'h400);
        check("full io_rw", {63'd0, oIO_RW}, 64'd0);
        @(negedge iCLOCK);
        iIO_VALID = 1; iIO_DATA = 32'h66;
        #2;
        check("pop b_valid", {63'd0, oB_VALID}, 64'd1);
        check("pop b_data", {32'd0, oB_DATA}, 64'h66);
        check("pop same cycle b_busy", {63'd0, oB_BUSY}, 64'd1);
        @(negedge iCLOCK);
        iIO_VALID = 0; iIO_DATA = 0;
        #2 check("after pop b_busy", {63'd0, oB_BUSY}, 64'd0);

        // IO stall for 3 cycles: slot held, both masters busy
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLOCK);
            drive_idle();
            iIO_BUSY = 1;
            iA_REQ = 1; iA_RW = 0; iA_ADDR = 32'h500;
            iB_REQ = 1; iB_RW = 1; iB_ADDR = 32'h320;
            #2;
            check($sformatf("stall io_addr %0d", i), {32'd0, oIO_ADDR}, 64'h310);
            check($sformatf("stall io_rw %0d", i), {63'd0, oIO_RW}, 64'd1);
            check($sformatf("stall a_busy %0d", i), {63'd0, oA_BUSY}, 64'd1);
            check($sformatf("stall b_busy %0d", i), {63'd0, oB_BUSY}, 64'd1);
        end
        @(negedge iCLOCK);
        iIO_BUSY = 0;
        #2;
        check("release a_grant", {63'd0, oA_BUSY}, 64'd0);
        check("release b_full", {63'd0, oB_BUSY}, 64'd1);

        // Mid-stream async reset
        @(negedge iCLOCK);
        drive_idle();
        iIO_VALID = 1; iIO_DATA = 32'h77;
        #2;
        check("pre-rst io_addr", {32'd0, oIO_ADDR}, 64'h500);
        check("pre-rst b_valid", {63'd0, oB_VALID}, 64'd1);
        check("pre-rst b_data", {32'd0, oB_DATA}, 64'h77);
        #1 inRESET = 1'b0;
        #1;
        check("rst io_req", {63'd0, oIO_REQ}, 64'd0);
        check("rst a_valid", {63'd0, oA_VALID}, 64'd0);
        check("rst b_valid", {63'd0, oB_VALID}, 64'd0);
        check("rst a_data", {32'd0, oA_DATA}, 64'd0);
        check("rst b_data", {32'd0, oB_DATA}, 64'd0);
        check("rst io_busy", {63'd0, oIO_BUSY}, 64'd0);
        check("rst error", {63'd0, oERROR}, 64'd0);
        @(negedge iCLOCK);
        inRESET = 1'b1;
        @(negedge iCLOCK);
        #2;
        check("post-rst error", {63'd0, oERROR}, 64'd1);
        check("post-rst b_valid", {63'd0, oB_VALID}, 64'd0);
        iIO_VALID = 0;
        @(negedge iCLOCK);
        #2 check("post-rst error clr", {63'd0, oERROR}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
